// File: rtl/reg32_avalon_master.sv
// -----------------------------------------------------------------------------
// reg32_avalon_master
//
// Avalon-MM master that runs one command at a time, taken from an exported
// conduit. A command is a run of single-word transfers at consecutive word
// addresses:
//   - write mode fills memory with an incrementing data pattern
//     (cmd_data, cmd_data+DATA_INC, ...)
//   - read mode streams every returned word back out on rd_data/rd_valid
//
// Ports
//   clock, resetn      system clock, asynchronous active-low reset
//   start              command strobe, only looked at while idle
//   cmd_write          1 = write sequence, 0 = read sequence
//   cmd_address        byte address of the first word ([1:0] ignored)
//   cmd_data           first write data word
//   cmd_byteenable     byteenable for every transfer of the sequence
//   cmd_count          number of transfers (0 = complete with no bus activity)
//   busy               high while a sequence is on the bus
//   done               one-cycle pulse when a sequence completes
//   rd_valid/rd_data   one-cycle pulse and data for each accepted read
//   address, read, write, byteenable, writedata,
//   readdata, waitrequest   Avalon-MM master interface
// -----------------------------------------------------------------------------
module reg32_avalon_master #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter logic [31:0] DATA_INC    = 32'd1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   cmd_write,
  input  logic [31:0]            cmd_address,
  input  logic [31:0]            cmd_data,
  input  logic [3:0]             cmd_byteenable,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_valid,
  output logic [31:0]            rd_data,
  output logic [31:0]            address,
  output logic                   read,
  output logic                   write,
  output logic [3:0]             byteenable,
  output logic [31:0]            writedata,
  input  logic [31:0]            readdata,
  input  logic                   waitrequest
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q,      state_d;
  logic                   busy_q,       busy_d;
  logic                   done_q,       done_d;
  logic                   rd_valid_q,   rd_valid_d;
  logic [31:0]            rd_data_q,    rd_data_d;
  logic [31:0]            address_q,    address_d;
  logic                   read_q,       read_d;
  logic                   write_q,      write_d;
  logic [3:0]             byteenable_q, byteenable_d;
  logic [31:0]            writedata_q,  writedata_d;
  logic [COUNT_WIDTH-1:0] remaining_q,  remaining_d;
  logic                   dir_q,        dir_d;  // 1 = write sequence

  // NOTE: every *_d gets a default at the top of the block so no path leaves
  // it unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    remaining_d  = remaining_q;
    dir_d        = dir_q;

    unique case (state_q)
      IDLE: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          address_d    = {cmd_address[31:2], 2'b00};
          writedata_d  = cmd_data;
          byteenable_d = cmd_byteenable;
          remaining_d  = cmd_count;
          dir_d        = cmd_write;
          if (cmd_count != '0) begin
            state_d = XFER;
            busy_d  = 1'b1;
            read_d  = ~cmd_write;
            write_d = cmd_write;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      XFER: begin
        // Request, address and data simply hold while the agent stalls.
        if (!waitrequest) begin
          remaining_d = remaining_q - COUNT_WIDTH'(1);
          address_d   = address_q + 32'd4;  // natural wrap past FFFFFFFC
          if (dir_q) begin
            writedata_d = writedata_q + DATA_INC;
          end else begin
            rd_data_d  = readdata;
            rd_valid_d = 1'b1;
          end
          // Last word: drop the request on the accepting edge so the agent
          // never sees a phantom extra transfer.
          if (remaining_q == COUNT_WIDTH'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            read_d  = 1'b0;
            write_d = 1'b0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        read_d  = 1'b0;
        write_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values computed above for this edge regardless of ordering.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      byteenable_q <= '0;
      writedata_q  <= '0;
      remaining_q  <= '0;
      dir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      remaining_q  <= remaining_d;
      dir_q        <= dir_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byteenable = byteenable_q;
  assign writedata  = writedata_q;

endmodule

// File: tb/tb_reg32_avalon_master.sv
// -----------------------------------------------------------------------------
// tb_reg32_avalon_master
//
// Bench for reg32_avalon_master. Each command is turned into a queue of the
// transfers it must produce (address, data, direction). A per-cycle compare
// task checks every DUT output against the head of that queue, plays the
// Avalon agent (waitrequest plan, read data from a small memory) and derives
// the next cycle's done/rd_valid expectations. Literal checks after each
// scenario pin the observed addresses, data and timing to hand-computed values.
// -----------------------------------------------------------------------------
module tb_reg32_avalon_master;

  localparam int          CW  = 16;
  localparam logic [31:0] INC = 32'd1;

  logic          clock = 1'b0;
  logic          resetn;
  logic          start;
  logic          cmd_write;
  logic [31:0]   cmd_address;
  logic [31:0]   cmd_data;
  logic [3:0]    cmd_byteenable;
  logic [CW-1:0] cmd_count;
  logic          busy, done, rd_valid;
  logic [31:0]   rd_data, address, writedata, readdata;
  logic          read, write, waitrequest;
  logic [3:0]    byteenable;

  always #5 clock = ~clock;

  reg32_avalon_master #(.COUNT_WIDTH(CW), .DATA_INC(INC)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start),
    .cmd_write      (cmd_write),
    .cmd_address    (cmd_address),
    .cmd_data       (cmd_data),
    .cmd_byteenable (cmd_byteenable),
    .cmd_count      (cmd_count),
    .busy           (busy),
    .done           (done),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .address        (address),
    .read           (read),
    .write          (write),
    .byteenable     (byteenable),
    .writedata      (writedata),
    .readdata       (readdata),
    .waitrequest    (waitrequest)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_write;
  } xfer_t;

  // Model state
  xfer_t       exp_q[$];
  logic [3:0]  exp_be;
  logic        exp_done, exp_rdv;
  logic [31:0] exp_rdata, last_rdata;
  logic [31:0] mem [logic [31:0]];
  int          wait_plan [8];
  int          wait_cnt, xfer_idx;

  // Observations for the literal checks
  int          cyc, start_cyc, first_bus_cyc, done_cyc;
  int          accept_cnt, hold_cnt, rdv_done_cnt;
  logic [31:0] acc_addr[$], acc_data[$], rd_log[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called once per cycle on the falling edge.
  task automatic check_cycle();
    logic have;
    int   plan;
    have = (exp_q.size() != 0);

    check1("rw_exclusive", read && write, 1'b0);
    check1("busy", busy, have);
    check1("done", done, exp_done);
    check1("rd_valid", rd_valid, exp_rdv);
    check("rd_data", rd_data, exp_rdv ? exp_rdata : last_rdata);
    if (have) begin
      check1("read", read, !exp_q[0].is_write);
      check1("write", write, exp_q[0].is_write);
      check("address", address, exp_q[0].addr);
      check("byteenable", {28'd0, byteenable}, {28'd0, exp_be});
      if (exp_q[0].is_write) check("writedata", writedata, exp_q[0].data);
    end else begin
      check1("read_idle", read, 1'b0);
      check1("write_idle", write, 1'b0);
    end

    if (exp_rdv) last_rdata = exp_rdata;
    if (rd_valid) rd_log.push_back(rd_data);
    if (done) done_cyc = cyc;
    if (done && rd_valid) rdv_done_cnt++;
    if ((read || write) && first_bus_cyc < 0) first_bus_cyc = cyc;
    if (write && address == 32'h14 && writedata == 32'hA1) hold_cnt++;

    // Agent response for the coming edge and next-cycle expectations.
    exp_done = 1'b0;
    exp_rdv  = 1'b0;
    if (have) begin
      plan = (xfer_idx < 8) ? wait_plan[xfer_idx] : 0;
      if (wait_cnt < plan) begin
        waitrequest = 1'b1;
        wait_cnt++;
      end else begin
        waitrequest = 1'b0;
        wait_cnt    = 0;
        if (exp_q[0].is_write) begin
          readdata = $urandom();
        end else begin
          readdata  = mem.exists(exp_q[0].addr) ? mem[exp_q[0].addr] : 32'h0;
          exp_rdv   = 1'b1;
          exp_rdata = readdata;
        end
        acc_addr.push_back(address);
        acc_data.push_back(writedata);
        accept_cnt++;
        xfer_idx++;
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) exp_done = 1'b1;
      end
    end else begin
      waitrequest = 1'b0;
      readdata    = 32'h0;
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  // Drive a start pulse; when accepted, build the transfer list it implies.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int cnt);
    logic [31:0] base;
    start          = 1'b1;
    cmd_write      = wr;
    cmd_address    = a;
    cmd_data       = d;
    cmd_byteenable = be;
    cmd_count      = CW'(cnt);
    step();
    start_cyc = cyc;
    start     = 1'b0;
    // Later command changes must have no effect.
    cmd_write      = ~wr;
    cmd_address    = ~a;
    cmd_data       = ~d;
    cmd_byteenable = ~be;
    cmd_count      = '1;
    first_bus_cyc = -1;
    done_cyc      = -1;
    accept_cnt    = 0;
    hold_cnt      = 0;
    rdv_done_cnt  = 0;
    xfer_idx      = 0;
    wait_cnt      = 0;
    acc_addr.delete();
    acc_data.delete();
    rd_log.delete();
    exp_be = be;
    base   = {a[31:2], 2'b00};
    if (cnt == 0) exp_done = 1'b1;
    for (int k = 0; k < cnt; k++)
      exp_q.push_back('{addr: base + 32'(4 * k), data: d + INC * 32'(k), is_write: wr});
  endtask

  task automatic run_until_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (exp_q.size() == 0 && !exp_done && !exp_rdv) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL timeout: sequence still pending after %0d cycles", max_cycles);
    exp_q.delete();
    exp_done = 1'b0;
    exp_rdv  = 1'b0;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 8; i++) wait_plan[i] = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_data = '0; cmd_byteenable = '0; cmd_count = '0;
    readdata = '0; waitrequest = 1'b0;
    exp_be = '0; exp_done = 1'b0; exp_rdv = 1'b0; exp_rdata = '0; last_rdata = '0;
    wait_cnt = 0; xfer_idx = 0; cyc = 0;
    start_cyc = 0; first_bus_cyc = -1; done_cyc = -1;
    accept_cnt = 0; hold_cnt = 0; rdv_done_cnt = 0;
    clear_plan();
    mem[32'h0] = 32'hDEADBEEF;
    mem[32'h4] = 32'h12345678;

    // Reset state
    #2;
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_rd_valid", rd_valid, 1'b0);
    check1("rst_read", read, 1'b0);
    check1("rst_write", write, 1'b0);
    check("rst_address", address, 32'h0);
    check("rst_writedata", writedata, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_byteenable", {28'd0, byteenable}, 32'h0);
    @(posedge clock); #1;
    resetn = 1'b1;
    step(); step();

    // Write fill, no wait states
    issue(1'b1, 32'h10, 32'hA0, 4'hF, 3);
    run_until_idle(20);
    check("t1_latency", 32'(first_bus_cyc - start_cyc), 32'd0);
    check("t1_done_at", 32'(done_cyc - start_cyc), 32'd3);
    check("t1_accepts", 32'(accept_cnt), 32'd3);
    if (acc_addr.size() == 3) begin
      check("t1_addr0", acc_addr[0], 32'h10); check("t1_data0", acc_data[0], 32'hA0);
      check("t1_addr1", acc_addr[1], 32'h14); check("t1_data1", acc_data[1], 32'hA1);
      check("t1_addr2", acc_addr[2], 32'h18); check("t1_data2", acc_data[2], 32'hA2);
    end
    step();

    // Same command, 4 wait states on the second transfer
    wait_plan[1] = 4;
    issue(1'b1, 32'h10, 32'hA0, 4'hF, 3);
    run_until_idle(30);
    check("t2_done_at", 32'(done_cyc - start_cyc), 32'd7);
    check("t2_accepts", 32'(accept_cnt), 32'd3);
    check("t2_hold_cycles", 32'(hold_cnt), 32'd5);
    clear_plan();
    step();

    // Read stream from an unaligned start address
    issue(1'b0, 32'h3, 32'h0, 4'hF, 2);
    run_until_idle(20);
    check("t3_words", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      check("t3_rd0", rd_log[0], 32'hDEADBEEF);
      check("t3_rd1", rd_log[1], 32'h12345678);
    end
    if (acc_addr.size() == 2) begin
      check("t3_addr0", acc_addr[0], 32'h0);
      check("t3_addr1", acc_addr[1], 32'h4);
    end
    check("t3_done_with_rdv", 32'(rdv_done_cnt), 32'd1);
    check("t3_done_at", 32'(done_cyc - start_cyc), 32'd2);
    step();
    check("t3_rd_data_hold", rd_data, 32'h12345678);

    // Zero count
    issue(1'b1, 32'h40, 32'h7, 4'h3, 0);
    run_until_idle(10);
    check("t4_done_at", 32'(done_cyc - start_cyc), 32'd0);
    check1("t4_no_bus", first_bus_cyc < 0, 1'b1);
    step();

    // Start while busy is ignored
    issue(1'b1, 32'h100, 32'h500, 4'hF, 3);
    step();
    start = 1'b1; cmd_write = 1'b0; cmd_address = 32'h800;
    cmd_data = 32'h999; cmd_byteenable = 4'h1; cmd_count = CW'(5);
    step();
    start = 1'b0;
    run_until_idle(20);
    check("t5_accepts", 32'(accept_cnt), 32'd3);
    if (acc_addr.size() == 3) begin
      check("t5_addr2", acc_addr[2], 32'h108);
      check("t5_data2", acc_data[2], 32'h502);
    end
    step(); step();

    // Address wrap
    issue(1'b1, 32'hFFFF_FFFC, 32'h55, 4'hF, 2);
    run_until_idle(20);
    if (acc_addr.size() == 2) begin
      check("t6_addr0", acc_addr[0], 32'hFFFF_FFFC);
      check("t6_addr1", acc_addr[1], 32'h0);
      check("t6_data1", acc_data[1], 32'h56);
    end else begin
      check("t6_accepts", 32'(acc_addr.size()), 32'd2);
    end
    step();

    // Reset in the middle of a sequence
    issue(1'b1, 32'h200, 32'h0, 4'hF, 4);
    step(); step();
    resetn = 1'b0;
    #1;
    check1("t7_write_drop", write, 1'b0);
    check1("t7_busy_drop", busy, 1'b0);
    check("t7_address_clr", address, 32'h0);
    exp_q.delete();
    exp_done   = 1'b0;
    exp_rdv    = 1'b0;
    last_rdata = 32'h0;
    done_cyc   = -1;
    step(); step();
    resetn = 1'b1;
    step(); step();
    check1("t7_no_done", done_cyc < 0, 1'b1);

    // New command after reset release
    issue(1'b0, 32'h4, 32'h0, 4'hC, 1);
    run_until_idle(20);
    check("t8_words", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() == 1) check("t8_rd0", rd_log[0], 32'h12345678);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg32_avalon_master.md
Name: reg32_avalon_master

Overview:
- Avalon-MM master: the initiator side of the 32-bit register agent interface already in the design.
- Accepts one command from an exported conduit, such as a switch/key controller or a test harness.
- Runs a sequence of single-word read or write transfers at consecutive word addresses.
- Write mode: fills memory with an incrementing data pattern. Read mode: streams each returned word out to the conduit.

Parameters:
- COUNT_WIDTH, 16, width of the transfer-count field; max transfers = 2^COUNT_WIDTH-1.
- DATA_INC, 32'd1, value added to writedata after each accepted write, modulo 2^32.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  command strobe; sampled only in IDLE
- cmd_write  in  1  1 = write sequence, 0 = read sequence
- cmd_address  in  32  byte address of first word; bits [1:0] ignored
- cmd_data  in  32  first write data word
- cmd_byteenable  in  4  byteenable used for every transfer in the sequence
- cmd_count  in  COUNT_WIDTH  number of transfers
- busy  out  1  high while a command is in progress
- done  out  1  one-cycle pulse when a sequence completes
- rd_valid  out  1  one-cycle pulse per accepted read
- rd_data  out  32  data captured for the most recent accepted read
- address  out  32  Avalon address, word-aligned ([1:0] = 0)
- read  out  1  Avalon read request
- write  out  1  Avalon write request
- byteenable  out  4  Avalon byteenable
- writedata  out  32  Avalon write data
- readdata  in  32  Avalon read data; valid when read=1 and waitrequest=0
- waitrequest  in  1  Avalon stall; the transfer is accepted on an edge where waitrequest=0

Behaviour:
- Registered outputs.
- Reset (asynchronous, resetn=0) clears the following:
  - state=IDLE
  - busy, done, rd_valid, read and write = 0
  - address, writedata, rd_data = 0
  - byteenable = 0
- States: IDLE, XFER, DONE.
- IDLE:
  - read=write=0, busy=0.
  - On an edge with start=1, latch the command: address = {cmd_address[31:2],2'b00}, writedata=cmd_data, byteenable=cmd_byteenable, remaining=cmd_count, dir=cmd_write.
  - If cmd_count != 0: go to XFER; busy=1 and read or write asserted from the next cycle. Start-to-bus latency is 1 cycle.
  - If cmd_count == 0: go to DONE with no bus activity.
- XFER:
  - Exactly one of read/write is high.
  - address, writedata, byteenable and read/write stay stable while waitrequest=1, for any number of cycles.
  - On an edge with waitrequest=0, the transfer is accepted:
    - remaining decrements; address += 4, wrapping 32'hFFFFFFFC -> 32'h0.
    - Write mode: writedata += DATA_INC, modulo 2^32.
    - Read mode: rd_data <= readdata; rd_valid=1 for the following cycle only.
  - If remaining was 1 at acceptance: go to DONE and drop read/write on that same edge, so there is no extra transfer.
  - Otherwise the next transfer is presented in the next cycle. Throughput is 1 transfer/cycle when waitrequest stays 0.
- DONE:
  - done=1 for exactly one cycle, busy=0, read=write=0; then go to IDLE.
  - For read mode, the rd_valid of the final word coincides with done.
- start while busy or in DONE: ignored, not queued.
- cmd_* inputs are sampled only on the accepting edge; later changes have no effect.
- rd_data holds its last value until the next accepted read.
- Reset mid-transfer: read/write fall immediately (asynchronously) and the sequence is abandoned. No done pulse; busy=0.
- Never assert read and write together.

Test Plan:
- Write fill, waitrequest=0: start with cmd_write=1, cmd_address=32'h0000_0010, cmd_data=32'h0000_00A0, cmd_count=3, be=4'hF.
  - Required: write high 3 consecutive cycles starting 1 cycle after start.
  - Required: (addr,data) = (0x10,0xA0),(0x14,0xA1),(0x18,0xA2).
  - Required: done pulses on the cycle after the last write; busy low.
- Wait-state hold: same write command with waitrequest=1 for 4 cycles on the 2nd transfer.
  - Required: address=0x14 and writedata=0xA1 stable all 4 cycles.
  - Required: exactly 3 accepted writes; done 4 cycles later than in the first test.
- Read stream: cmd_write=0, cmd_address=32'h0000_0003, count=2, with the agent returning 32'hDEADBEEF then 32'h12345678.
  - Required: addresses 0x0 then 0x4.
  - Required: rd_valid pulses twice with rd_data=DEADBEEF, then 12345678.
  - Required: done coincides with the second rd_valid.
- Zero count and start while busy: cmd_count=0 -> no read/write, done pulses 1 cycle after start.
  - During a 3-word sequence, pulse start with new values -> ignored; original sequence completes unchanged.
- Wrap and reset: cmd_address=32'hFFFF_FFFC, count=2 -> addresses FFFFFFFC then 00000000.
  - Separately, assert resetn=0 mid-sequence -> write/busy drop immediately, no done.
  - After release, a new start works normally.
